// File: rtl/map_arb_pkg.sv
// ---------------------------------------------------------------------------
// map_arb_pkg
// Shared definitions for the tile-map access arbiter: maze geometry, default
// bus widths, tile code constants and the read-owner pipeline record.
// No ports (package).
// ---------------------------------------------------------------------------
package map_arb_pkg;

    localparam int MAP_ROWS = 36;
    localparam int MAP_COLS = 28;
    localparam int ADDR_W   = 10;
    localparam int DATA_W   = 8;

    localparam logic [7:0] TILE_EMPTY  = 8'h00;
    localparam logic [7:0] TILE_WALL   = 8'h01;
    localparam logic [7:0] TILE_PELLET = 8'h02;
    localparam logic [7:0] TILE_POWER  = 8'h03;

    // Wide enough for the largest supported requester count (8).
    localparam int OWNER_IDX_W = 3;

    // Who gets the RAM read data that comes back one cycle later.
    typedef struct packed {
        logic                   vga_rd;
        logic                   game_rd;
        logic [OWNER_IDX_W-1:0] idx;
    } owner_t;

    // Linear tile address for a (row, col) board position.
    function automatic logic [ADDR_W-1:0] tile_addr(input int row, input int col);
        return ADDR_W'(row * MAP_COLS + col);
    endfunction

endpackage

// File: rtl/map_access_arbiter_rr_picker.sv
// ---------------------------------------------------------------------------
// rr_picker
// Combinational round-robin pick among N_REQ request lines. The search
// starts one past the previous winner and wraps, so the last winner has the
// lowest priority.
// Ports:
//   req   in   N_REQ   request lines
//   last  in   IDX_W   index of the previous winner
//   gnt   out  N_REQ   one-hot pick (all zero when no request)
//   idx   out  IDX_W   index of the pick (0 when no request)
// ---------------------------------------------------------------------------
module rr_picker #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] idx
);

    import map_arb_pkg::*;

    logic             found;
    int               cand;
    logic [IDX_W-1:0] cand_idx;

    always_comb begin
        gnt      = '0;
        idx      = '0;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        // Offsets 1..N_REQ visit every requester once, last winner visited last.
        for (int i = 1; i <= N_REQ; i++) begin
            cand     = (int'(last) + i) % N_REQ;
            cand_idx = IDX_W'(cand);
            if (!found && req[cand_idx]) begin
                found         = 1'b1;
                gnt[cand_idx] = 1'b1;
                idx           = cand_idx;
            end
        end
    end

endmodule

// File: rtl/map_access_arbiter.sv
// ---------------------------------------------------------------------------
// map_access_arbiter
// Shares the single-port tile-map RAM between the VGA tile fetcher (absolute
// priority) and N_REQ game-logic requesters (round-robin). Read data comes
// back one cycle after the access and is steered to its owner.
// Ports:
//   i_clk, i_rst              clock, async active-high reset
//   i_vga_req/i_vga_addr      VGA read request, always accepted
//   o_vga_data/o_vga_valid    VGA read return (held when not valid)
//   i_req/i_we/i_addr/i_wdata game requests, packed per requester
//   o_gnt                     one-hot grant, same cycle as the RAM access
//   o_rdata/o_rvalid          game read return (held when not valid)
//   o_starved/i_starve_clr    sticky starvation flags and their clear
//   o_mem_*/i_mem_rdata       RAM port, 1-cycle read latency
// ---------------------------------------------------------------------------
module map_access_arbiter #(
    parameter int N_REQ    = 4,
    parameter int ADDR_W   = map_arb_pkg::ADDR_W,
    parameter int DATA_W   = map_arb_pkg::DATA_W,
    parameter int MAX_WAIT = 63
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_vga_req,
    input  logic [ADDR_W-1:0]         i_vga_addr,
    output logic [DATA_W-1:0]         o_vga_data,
    output logic                      o_vga_valid,
    input  logic [N_REQ-1:0]          i_req,
    input  logic [N_REQ-1:0]          i_we,
    input  logic [N_REQ*ADDR_W-1:0]   i_addr,
    input  logic [N_REQ*DATA_W-1:0]   i_wdata,
    output logic [N_REQ-1:0]          o_gnt,
    output logic [DATA_W-1:0]         o_rdata,
    output logic [N_REQ-1:0]          o_rvalid,
    output logic [N_REQ-1:0]          o_starved,
    input  logic                      i_starve_clr,
    output logic [ADDR_W-1:0]         o_mem_addr,
    output logic                      o_mem_we,
    output logic [DATA_W-1:0]         o_mem_wdata,
    input  logic [DATA_W-1:0]         i_mem_rdata
);

    import map_arb_pkg::*;

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    logic [IDX_W-1:0]  last_gnt;
    logic [IDX_W-1:0]  pick_idx;
    logic [N_REQ-1:0]  pick_gnt;
    logic              vga_go;
    logic              game_go;
    owner_t            owner_d;
    owner_t            owner_q;
    logic [DATA_W-1:0] vga_hold;
    logic [DATA_W-1:0] game_hold;
    logic [CNT_W-1:0]  wait_cnt [N_REQ];
    logic [N_REQ-1:0]  starved_set;

    rr_picker #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .req  (i_req),
        .last (last_gnt),
        .gnt  (pick_gnt),
        .idx  (pick_idx)
    );

    // Reset also blocks the combinational grant/RAM path so every output is 0.
    assign vga_go  = i_vga_req & ~i_rst;
    assign game_go = ~i_vga_req & ~i_rst & (|i_req);
    assign o_gnt   = game_go ? pick_gnt : '0;

    always_comb begin
        o_mem_addr  = '0;
        o_mem_we    = 1'b0;
        o_mem_wdata = '0;
        if (vga_go) begin
            o_mem_addr = i_vga_addr;
        end else if (game_go) begin
            o_mem_addr  = i_addr[pick_idx*ADDR_W +: ADDR_W];
            o_mem_we    = i_we[pick_idx];
            o_mem_wdata = i_wdata[pick_idx*DATA_W +: DATA_W];
        end
    end

    // Writes never return data, so only game reads mark the owner pipeline.
    always_comb begin
        owner_d         = '0;
        owner_d.vga_rd  = vga_go;
        owner_d.game_rd = game_go & ~i_we[pick_idx];
        owner_d.idx     = OWNER_IDX_W'(pick_idx);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            owner_q   <= '0;
            last_gnt  <= IDX_W'(N_REQ - 1);
            vga_hold  <= DATA_W'(TILE_EMPTY);
            game_hold <= DATA_W'(TILE_EMPTY);
        end else begin
            owner_q <= owner_d;
            if (game_go) begin
                last_gnt <= pick_idx;
            end
            if (owner_q.vga_rd) begin
                vga_hold <= i_mem_rdata;
            end
            if (owner_q.game_rd) begin
                game_hold <= i_mem_rdata;
            end
        end
    end

    // RAM data arrives during the cycle after the access; pass it straight through.
    assign o_vga_valid = owner_q.vga_rd;
    assign o_vga_data  = owner_q.vga_rd ? i_mem_rdata : vga_hold;
    assign o_rvalid    = owner_q.game_rd ? (N_REQ'(1) << owner_q.idx) : '0;
    assign o_rdata     = owner_q.game_rd ? i_mem_rdata : game_hold;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int k = 0; k < N_REQ; k++) begin
                wait_cnt[k] <= '0;
            end
        end else begin
            for (int k = 0; k < N_REQ; k++) begin
                if (!i_req[k] || o_gnt[k]) begin
                    wait_cnt[k] <= '0;
                end else if (wait_cnt[k] != CNT_W'(MAX_WAIT)) begin
                    wait_cnt[k] <= wait_cnt[k] + 1'b1;
                end
            end
        end
    end

    // Flag sets on the same edge the counter reaches MAX_WAIT (or while saturated).
    always_comb begin
        starved_set = '0;
        for (int k = 0; k < N_REQ; k++) begin
            starved_set[k] = i_req[k] & ~o_gnt[k] &
                             (wait_cnt[k] >= CNT_W'(MAX_WAIT - 1));
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_starved <= '0;
        end else begin
            o_starved <= (o_starved & ~{N_REQ{i_starve_clr}}) | starved_set;
        end
    end

endmodule

// File: tb/tb_map_access_arbiter.sv
// ---------------------------------------------------------------------------
// tb_map_access_arbiter
// Directed bench for map_access_arbiter with a behavioural 1-cycle RAM.
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit
// later, well away from the next edge.
// ---------------------------------------------------------------------------
module tb_map_access_arbiter;

    localparam int N_REQ  = 4;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 8;

    logic                    clk;
    logic                    rst;
    logic                    vga_req;
    logic [ADDR_W-1:0]       vga_addr;
    logic [DATA_W-1:0]       vga_data;
    logic                    vga_valid;
    logic [N_REQ-1:0]        req;
    logic [N_REQ-1:0]        we;
    logic [N_REQ*ADDR_W-1:0] addr_bus;
    logic [N_REQ*DATA_W-1:0] wdata_bus;
    logic [N_REQ-1:0]        gnt;
    logic [DATA_W-1:0]       rdata;
    logic [N_REQ-1:0]        rvalid;
    logic [N_REQ-1:0]        starved;
    logic                    starve_clr;
    logic [ADDR_W-1:0]       mem_addr;
    logic                    mem_we;
    logic [DATA_W-1:0]       mem_wdata;
    logic [DATA_W-1:0]       mem_rdata;

    logic [DATA_W-1:0]       ram [1024];

    int checks   = 0;
    int failures = 0;

    map_access_arbiter #(
        .N_REQ    (N_REQ),
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .MAX_WAIT (63)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_vga_req    (vga_req),
        .i_vga_addr   (vga_addr),
        .o_vga_data   (vga_data),
        .o_vga_valid  (vga_valid),
        .i_req        (req),
        .i_we         (we),
        .i_addr       (addr_bus),
        .i_wdata      (wdata_bus),
        .o_gnt        (gnt),
        .o_rdata      (rdata),
        .o_rvalid     (rvalid),
        .o_starved    (starved),
        .i_starve_clr (starve_clr),
        .o_mem_addr   (mem_addr),
        .o_mem_we     (mem_we),
        .o_mem_wdata  (mem_wdata),
        .i_mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous single-port RAM, read-before-write within a cycle.
    always @(posedge clk) begin
        if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
        end
        mem_rdata <= ram[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_slot(input int k, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        addr_bus[k*ADDR_W +: ADDR_W]  = a;
        wdata_bus[k*DATA_W +: DATA_W] = d;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired before the sequence completed");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
        ram[10]  = 8'h11;
        ram[29]  = 8'h02;
        ram[50]  = 8'h33;
        ram[100] = 8'h05;
        mem_rdata  = '0;

        rst        = 1'b1;
        vga_req    = 1'b0;
        vga_addr   = '0;
        req        = '0;
        we         = '0;
        addr_bus   = '0;
        wdata_bus  = '0;
        starve_clr = 1'b0;

        // Reset state
        step(); step();
        check("rst_gnt", gnt, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_vga_valid", vga_valid, 0);
        check("rst_starved", starved, 0);
        check("rst_rdata", rdata, 0);
        check("rst_vga_data", vga_data, 0);
        check("rst_mem_we", mem_we, 0);
        rst = 1'b0;

        // All four requesting: round robin 0,1,2,3,0
        step();
        set_slot(0, 10'd10, 8'h00);
        set_slot(1, 10'd29, 8'h00);
        set_slot(2, 10'd50, 8'h00);
        set_slot(3, 10'd100, 8'h00);
        req = 4'b1111;
        #1;
        check("rr_gnt0", gnt, 4'b0001);
        check("rr_addr0", mem_addr, 10);
        step(); #1;
        check("rr_gnt1", gnt, 4'b0010);
        check("rr_rvalid0", rvalid, 4'b0001);
        check("rr_rdata0", rdata, 8'h11);
        step(); #1;
        check("rr_gnt2", gnt, 4'b0100);
        check("rr_rvalid1", rvalid, 4'b0010);
        check("rr_rdata1", rdata, 8'h02);
        step(); #1;
        check("rr_gnt3", gnt, 4'b1000);
        check("rr_rvalid2", rvalid, 4'b0100);
        check("rr_rdata2", rdata, 8'h33);
        step(); #1;
        check("rr_gnt0_again", gnt, 4'b0001);
        check("rr_rvalid3", rvalid, 4'b1000);
        check("rr_rdata3", rdata, 8'h05);
        step();
        req = 4'b0000;
        #1;
        check("idle_gnt", gnt, 0);
        check("rr_rvalid0_again", rvalid, 4'b0001);
        check("rr_rdata0_again", rdata, 8'h11);

        // Requester 1 reads addr 29 (pellet); read data held meanwhile
        step();
        req = 4'b0010;
        #1;
        check("rd1_gnt", gnt, 4'b0010);
        check("hold_rvalid", rvalid, 0);
        check("hold_rdata", rdata, 8'h11);

        // Requester 0 writes 0 to addr 100, requester 3 then reads it
        step();
        req = 4'b0001;
        we  = 4'b0001;
        set_slot(0, 10'd100, 8'h00);
        #1;
        check("rd1_rvalid", rvalid, 4'b0010);
        check("rd1_rdata", rdata, 8'h02);
        check("wr0_gnt", gnt, 4'b0001);
        check("wr0_mem_we", mem_we, 1);
        check("wr0_mem_addr", mem_addr, 100);
        check("wr0_mem_wdata", mem_wdata, 8'h00);
        step();
        req = 4'b1000;
        we  = 4'b0000;
        #1;
        check("rd3_gnt", gnt, 4'b1000);
        check("wr0_no_rvalid", rvalid, 0);
        check("wr0_rdata_hold", rdata, 8'h02);
        step();
        req = 4'b0000;
        #1;
        check("raw_rvalid", rvalid, 4'b1000);
        check("raw_rdata", rdata, 8'h00);

        // Alternating VGA with requesters 0 and 2
        step();
        set_slot(0, 10'd10, 8'h00);
        vga_req  = 1'b1;
        vga_addr = 10'd29;
        req      = 4'b0101;
        #1;
        check("alt_a_gnt", gnt, 0);
        check("alt_a_mem_addr", mem_addr, 29);
        check("alt_a_mem_we", mem_we, 0);
        step();
        vga_req = 1'b0;
        #1;
        check("alt_b_gnt", gnt, 4'b0001);
        check("alt_b_vga_valid", vga_valid, 1);
        check("alt_b_vga_data", vga_data, 8'h02);
        step();
        vga_req  = 1'b1;
        vga_addr = 10'd10;
        #1;
        check("alt_c_gnt", gnt, 0);
        check("alt_c_vga_valid", vga_valid, 0);
        check("alt_c_rvalid", rvalid, 4'b0001);
        check("alt_c_rdata", rdata, 8'h11);
        step();
        vga_req = 1'b0;
        #1;
        check("alt_d_gnt", gnt, 4'b0100);
        check("alt_d_vga_data", vga_data, 8'h11);
        step();
        vga_req  = 1'b1;
        vga_addr = 10'd50;
        #1;
        check("alt_e_gnt", gnt, 0);
        check("alt_e_rvalid", rvalid, 4'b0100);
        check("alt_e_rdata", rdata, 8'h33);
        step();
        vga_req = 1'b0;
        req     = 4'b0000;
        #1;
        check("alt_f_vga_valid", vga_valid, 1);
        check("alt_f_vga_data", vga_data, 8'h33);
        step(); #1;
        check("alt_g_vga_valid", vga_valid, 0);
        check("alt_g_vga_hold", vga_data, 8'h33);

        // VGA holds the RAM for 70 cycles while requester 2 waits
        step();
        vga_req  = 1'b1;
        vga_addr = 10'd29;
        req      = 4'b0100;
        #1;
        check("starve_gnt_c1", gnt, 0);
        for (int c = 2; c <= 70; c++) begin
            step();
            check("starve_gnt", gnt, 0);
            if (c == 63) check("starve_c63", starved, 4'b0000);
            if (c == 64) check("starve_c64", starved, 4'b0100);
        end
        check("starve_c70", starved, 4'b0100);
        step();
        vga_req = 1'b0;
        #1;
        check("starve_release_gnt", gnt, 4'b0100);
        check("starve_vga_valid", vga_valid, 1);
        check("starve_vga_data", vga_data, 8'h02);
        step();
        req = 4'b0000;
        #1;
        check("starve_rvalid", rvalid, 4'b0100);
        check("starve_rdata", rdata, 8'h33);
        check("starve_sticky", starved, 4'b0100);
        step();
        starve_clr = 1'b1;
        #1;
        check("starve_before_clr", starved, 4'b0100);
        step();
        starve_clr = 1'b0;
        #1;
        check("starve_cleared", starved, 0);

        // Reset while a read is in flight
        step();
        req = 4'b0001;
        #1;
        check("rst_flight_gnt", gnt, 4'b0001);
        step();
        rst = 1'b1;
        req = 4'b1111;
        #1;
        check("rst_flight_rvalid", rvalid, 0);
        check("rst_flight_gnt_blocked", gnt, 0);
        step();
        check("rst2_rvalid", rvalid, 0);
        check("rst2_rdata", rdata, 0);
        check("rst2_vga_data", vga_data, 0);
        step();
        rst = 1'b0;
        #1;
        check("post_rst_gnt", gnt, 4'b0001);
        check("post_rst_rvalid", rvalid, 0);
        step(); #1;
        check("post_rst_gnt1", gnt, 4'b0010);
        check("post_rst_rvalid0", rvalid, 4'b0001);
        check("post_rst_rdata0", rdata, 8'h11);
        req = 4'b0000;

        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
